// File: rtl/sound_mailbox_fifo.sv
// Bidirectional 68k <-> 6502 sound mailbox: command and reply FWFT FIFOs with
// strobe synchronisation, occupancy counts, sticky overflow flags and a stretchable NMI.

module sound_mailbox_fifo #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int NMI_LEN = 32,
   parameter int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk100,
   input  logic             rst_b,
   // 68k side
   input  logic [WIDTH-1:0] Dout68k,
   input  logic             SNDWR_b,
   input  logic             SNDRD_b,
   output logic [WIDTH-1:0] Din68k,
   output logic             SNDINT_b,
   // 6502 side
   input  logic [WIDTH-1:0] Dout6502,
   input  logic             WR68k_b,
   input  logic             RD68k_b,
   output logic [WIDTH-1:0] Din6502,
   output logic             SNDNMI_b,
   // status
   output logic             ctrl_SNDBUF,
   output logic             ctrl_68kBUF,
   output logic [CW-1:0]    cmd_count,
   output logic [CW-1:0]    rpl_count,
   output logic             cmd_full,
   output logic             rpl_full,
   output logic             cmd_ovf,
   output logic             rpl_ovf,
   input  logic             ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(NMI_LEN + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [NW-1:0] nmi_cnt;

   // Channel 0 is the command FIFO (68k -> 6502), channel 1 the reply FIFO (6502 -> 68k).
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic             wr_b;
      logic             rd_b;
      logic [WIDTH-1:0] wr_data;
      logic [1:0]       wr_sync;
      logic [1:0]       rd_sync;
      logic             wr_hist;
      logic             rd_hist;
      logic             push_edge;
      logic             pop_edge;
      logic             do_push;
      logic             do_pop;
      logic             ovf_ev;
      logic             full;
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr;
      logic [CW-1:0]    count;
      logic             ovf;
      logic [WIDTH-1:0] rd_data;
      logic [WIDTH-1:0] mem [DEPTH];

      always_comb begin
         wr_b    = (c == 0) ? SNDWR_b : WR68k_b;
         rd_b    = (c == 0) ? RD68k_b : SNDRD_b;
         wr_data = (c == 0) ? Dout68k : Dout6502;
      end

      // Flops reset to 0, so a strobe held low through reset must go high then low to act.
      always_ff @(posedge clk100 or negedge rst_b) begin
         if (!rst_b) begin
            wr_sync <= '0;
            rd_sync <= '0;
            wr_hist <= 1'b0;
            rd_hist <= 1'b0;
         end else begin
            wr_sync <= {wr_sync[0], wr_b};
            rd_sync <= {rd_sync[0], rd_b};
            wr_hist <= wr_sync[1];
            rd_hist <= rd_sync[1];
         end
      end

      // A pop on a full FIFO frees the slot, so a coincident push is accepted, not an overflow.
      always_comb begin
         push_edge = !wr_sync[1] && wr_hist;
         pop_edge  = rd_sync[1] && !rd_hist;
         full      = (count == FULL_CNT);
         do_pop    = pop_edge && (count != '0);
         do_push   = push_edge && (!full || do_pop);
         ovf_ev    = push_edge && full && !do_pop;
         rd_data   = (count != '0) ? mem[rd_ptr] : '1;
      end

      always_ff @(posedge clk100 or negedge rst_b) begin
         if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (ovf_ev)       ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
         end
      end

      always_ff @(posedge clk100) begin
         if (do_push) mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk100 or negedge rst_b) begin
      if (!rst_b)                nmi_cnt <= '0;
      else if (g_ch[0].do_push)  nmi_cnt <= NW'(NMI_LEN);
      else if (nmi_cnt != '0)    nmi_cnt <= nmi_cnt - NW'(1);
   end

   always_comb begin
      cmd_count   = g_ch[0].count;
      rpl_count   = g_ch[1].count;
      cmd_full    = g_ch[0].full;
      rpl_full    = g_ch[1].full;
      cmd_ovf     = g_ch[0].ovf;
      rpl_ovf     = g_ch[1].ovf;
      Din6502     = g_ch[0].rd_data;
      Din68k      = g_ch[1].rd_data;
      ctrl_SNDBUF = (g_ch[0].count != '0);
      ctrl_68kBUF = (g_ch[1].count != '0);
      SNDINT_b    = (g_ch[1].count == '0);
      SNDNMI_b    = (nmi_cnt == '0);
   end

endmodule

// File: tb/tb_sound_mailbox_fifo.sv
// Bench for sound_mailbox_fifo: directed scenarios plus randomized strobes, all
// checked every cycle against a queue-based model of the two mailboxes.

module tb_sound_mailbox_fifo;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int NMI_LEN = 32;
   localparam int CW      = $clog2(DEPTH + 1);

   logic             clk100   = 1'b0;
   logic             rst_b    = 1'b0;
   logic [WIDTH-1:0] Dout68k  = '0;
   logic [WIDTH-1:0] Dout6502 = '0;
   logic             SNDWR_b  = 1'b1;
   logic             SNDRD_b  = 1'b1;
   logic             WR68k_b  = 1'b1;
   logic             RD68k_b  = 1'b1;
   logic             ovf_clr  = 1'b0;
   logic [WIDTH-1:0] Din68k, Din6502;
   logic             SNDINT_b, SNDNMI_b, ctrl_SNDBUF, ctrl_68kBUF;
   logic             cmd_full, rpl_full, cmd_ovf, rpl_ovf;
   logic [CW-1:0]    cmd_count, rpl_count;

   sound_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NMI_LEN(NMI_LEN)) dut (
      .clk100(clk100), .rst_b(rst_b),
      .Dout68k(Dout68k), .SNDWR_b(SNDWR_b), .SNDRD_b(SNDRD_b),
      .Din68k(Din68k), .SNDINT_b(SNDINT_b),
      .Dout6502(Dout6502), .WR68k_b(WR68k_b), .RD68k_b(RD68k_b),
      .Din6502(Din6502), .SNDNMI_b(SNDNMI_b),
      .ctrl_SNDBUF(ctrl_SNDBUF), .ctrl_68kBUF(ctrl_68kBUF),
      .cmd_count(cmd_count), .rpl_count(rpl_count),
      .cmd_full(cmd_full), .rpl_full(rpl_full),
      .cmd_ovf(cmd_ovf), .rpl_ovf(rpl_ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk100 = ~clk100;

   // Model state. Strobe index: 0 SNDWR_b, 1 RD68k_b, 2 WR68k_b, 3 SNDRD_b.
   logic [WIDTH-1:0] cmd_q[$];
   logic [WIDTH-1:0] rpl_q[$];
   bit               m_cmd_ovf, m_rpl_ovf;
   int               m_nmi;
   int               pend [4];
   logic [WIDTH-1:0] pdata [4];
   int               held [4];
   int               nmi_low;
   int               checks;
   int               errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic strobe_level(input int s);
      case (s)
         0:       return SNDWR_b;
         1:       return RD68k_b;
         2:       return WR68k_b;
         default: return SNDRD_b;
      endcase
   endfunction

   // Changes are made just after a rising edge; the operation commits three edges later.
   task automatic set_strobe(input int s, input logic lvl, input logic [WIDTH-1:0] d);
      logic prev;
      prev = strobe_level(s);
      if (prev == lvl) return;
      held[s] = 0;
      if ((s % 2 == 0) ? !lvl : lvl) begin
         pend[s]  = 3;
         pdata[s] = d;
      end
      case (s)
         0: begin SNDWR_b = lvl; if (!lvl) Dout68k = d; end
         1: RD68k_b = lvl;
         2: begin WR68k_b = lvl; if (!lvl) Dout6502 = d; end
         default: SNDRD_b = lvl;
      endcase
   endtask

   task automatic model_reset();
      cmd_q.delete();
      rpl_q.delete();
      m_cmd_ovf = 0;
      m_rpl_ovf = 0;
      m_nmi     = 0;
      for (int s = 0; s < 4; s++) pend[s] = 0;
   endtask

   task automatic model_edge();
      bit fire [4];
      bit acc, ovf_c, ovf_r;
      for (int s = 0; s < 4; s++) begin
         fire[s] = 0;
         if (pend[s] > 0) begin
            pend[s]--;
            fire[s] = (pend[s] == 0);
         end
      end
      acc = 0; ovf_c = 0; ovf_r = 0;
      if (fire[1] && cmd_q.size() > 0) void'(cmd_q.pop_front());
      if (fire[0]) begin
         if (cmd_q.size() < DEPTH) begin cmd_q.push_back(pdata[0]); acc = 1; end
         else ovf_c = 1;
      end
      if (fire[3] && rpl_q.size() > 0) void'(rpl_q.pop_front());
      if (fire[2]) begin
         if (rpl_q.size() < DEPTH) rpl_q.push_back(pdata[2]);
         else ovf_r = 1;
      end
      if (ovf_c)        m_cmd_ovf = 1;
      else if (ovf_clr) m_cmd_ovf = 0;
      if (ovf_r)        m_rpl_ovf = 1;
      else if (ovf_clr) m_rpl_ovf = 0;
      if (acc)            m_nmi = NMI_LEN;
      else if (m_nmi > 0) m_nmi--;
   endtask

   task automatic check_all();
      check("cmd_count", 32'(cmd_count), 32'(cmd_q.size()));
      check("rpl_count", 32'(rpl_count), 32'(rpl_q.size()));
      check("cmd_full", 32'(cmd_full), 32'(cmd_q.size() == DEPTH));
      check("rpl_full", 32'(rpl_full), 32'(rpl_q.size() == DEPTH));
      check("cmd_ovf", 32'(cmd_ovf), 32'(m_cmd_ovf));
      check("rpl_ovf", 32'(rpl_ovf), 32'(m_rpl_ovf));
      check("Din6502", 32'(Din6502), (cmd_q.size() != 0) ? 32'(cmd_q[0]) : 32'({WIDTH{1'b1}}));
      check("Din68k", 32'(Din68k), (rpl_q.size() != 0) ? 32'(rpl_q[0]) : 32'({WIDTH{1'b1}}));
      check("ctrl_SNDBUF", 32'(ctrl_SNDBUF), 32'(cmd_q.size() != 0));
      check("ctrl_68kBUF", 32'(ctrl_68kBUF), 32'(rpl_q.size() != 0));
      check("SNDINT_b", 32'(SNDINT_b), 32'(rpl_q.size() == 0));
      check("SNDNMI_b", 32'(SNDNMI_b), 32'(m_nmi == 0));
   endtask

   task automatic step();
      @(posedge clk100);
      if (rst_b) model_edge();
      #1;
      for (int s = 0; s < 4; s++) held[s]++;
      if (!SNDNMI_b) nmi_low++;
      check_all();
   endtask

   task automatic pulse(input int s, input logic [WIDTH-1:0] d);
      set_strobe(s, 1'b0, d);
      repeat (3) step();
      set_strobe(s, 1'b1, d);
      repeat (3) step();
   endtask

   // Strobes enabled in act_mask toggle at random (respecting 3-cycle widths); others idle high.
   task automatic random_run(input int cycles, input int act_mask);
      logic lvl;
      for (int c = 0; c < cycles; c++) begin
         for (int s = 0; s < 4; s++) begin
            if (held[s] >= 3) begin
               lvl = strobe_level(s);
               if (act_mask[s] ? ($urandom_range(0, 3) == 0) : (lvl == 1'b0))
                  set_strobe(s, ~lvl, WIDTH'($urandom));
            end
         end
         ovf_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      ovf_clr = 1'b0;
   endtask

   logic [WIDTH-1:0] exp_order [4];

   initial begin
      checks = 0;
      errors = 0;
      nmi_low = 0;
      model_reset();
      for (int s = 0; s < 4; s++) held[s] = 3;

      // Reset values, with SNDWR_b held low across release.
      SNDWR_b = 1'b0;
      held[0] = 0;
      repeat (3) step();
      rst_b = 1'b1;
      repeat (8) step();
      check("held_low_no_push", 32'(cmd_count), 32'd0);
      set_strobe(0, 1'b1, '0);
      repeat (3) step();

      // Single write: commit latency and NMI width.
      nmi_low = 0;
      set_strobe(0, 1'b0, 8'h42);
      repeat (2) step();
      check("pre_commit_count", 32'(cmd_count), 32'd0);
      step();
      check("commit_count", 32'(cmd_count), 32'd1);
      check("commit_din6502", 32'(Din6502), 32'h42);
      check("commit_sndbuf", 32'(ctrl_SNDBUF), 32'd1);
      repeat (2) step();
      set_strobe(0, 1'b1, '0);
      repeat (50) step();
      check("nmi_width", 32'(nmi_low), 32'(NMI_LEN));

      // Second write 10 cycles after the first stretches NMI.
      nmi_low = 0;
      set_strobe(0, 1'b0, 8'h43);
      repeat (5) step();
      set_strobe(0, 1'b1, '0);
      repeat (5) step();
      set_strobe(0, 1'b0, 8'h44);
      repeat (5) step();
      set_strobe(0, 1'b1, '0);
      repeat (60) step();
      check("nmi_stretch", 32'(nmi_low), 32'(NMI_LEN + 10));
      repeat (3) pulse(1, '0);

      // Fill to DEPTH, overflow, then drain in order.
      for (int i = 1; i <= 4; i++) pulse(0, WIDTH'(i));
      check("full_after_4", 32'(cmd_full), 32'd1);
      repeat (40) step();
      pulse(0, 8'h05);
      check("ovf_5th", 32'(cmd_ovf), 32'd1);
      check("ovf_no_nmi", 32'(SNDNMI_b), 32'd1);
      check("ovf_count", 32'(cmd_count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", 32'(Din6502), 32'(i));
         pulse(1, '0);
      end
      check("drained_din", 32'(Din6502), 32'hFF);
      pulse(1, '0);
      check("pop_empty_count", 32'(cmd_count), 32'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      step();
      check("ovf_cleared", 32'(cmd_ovf), 32'd0);

      // Reply FIFO pointer wrap.
      for (int i = 0; i < 10; i++) begin
         pulse(2, WIDTH'(8'hA0 + i));
         check("wrap_din68k", 32'(Din68k), 32'(8'hA0 + i));
         check("wrap_int_low", 32'(SNDINT_b), 32'd0);
         pulse(3, '0);
         check("wrap_int_high", 32'(SNDINT_b), 32'd1);
      end

      // Full FIFO with push and pop committing on the same edge.
      for (int i = 0; i < 4; i++) pulse(0, WIDTH'(8'h10 + i));
      set_strobe(1, 1'b0, '0);
      repeat (3) step();
      set_strobe(0, 1'b0, 8'h20);
      set_strobe(1, 1'b1, '0);
      repeat (3) step();
      check("full_pushpop_count", 32'(cmd_count), 32'd4);
      check("full_pushpop_ovf", 32'(cmd_ovf), 32'd0);
      set_strobe(0, 1'b1, '0);
      repeat (3) step();

      // ovf_clr coinciding with an overflow push: set wins.
      set_strobe(0, 1'b0, 8'h30);
      repeat (2) step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("clr_vs_set", 32'(cmd_ovf), 32'd1);
      set_strobe(0, 1'b1, '0);
      repeat (3) step();
      exp_order[0] = 8'h11; exp_order[1] = 8'h12; exp_order[2] = 8'h13; exp_order[3] = 8'h20;
      for (int i = 0; i < 4; i++) begin
         check("pushpop_order", 32'(Din6502), 32'(exp_order[i]));
         pulse(1, '0);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      step();

      // Asynchronous reset mid-NMI with three entries queued.
      for (int i = 0; i < 3; i++) pulse(0, WIDTH'(8'h51 + i));
      step();
      check("pre_reset_nmi", 32'(SNDNMI_b), 32'd0);
      check("pre_reset_count", 32'(cmd_count), 32'd3);
      rst_b = 1'b0;
      model_reset();
      #1;
      check("async_rst_count", 32'(cmd_count), 32'd0);
      check("async_rst_nmi", 32'(SNDNMI_b), 32'd1);
      check("async_rst_din", 32'(Din6502), 32'hFF);
      repeat (3) step();
      rst_b = 1'b1;
      repeat (5) step();

      // Randomized traffic: write-heavy, mixed, read-heavy, mixed.
      random_run(400, 4'b0101);
      random_run(600, 4'b1111);
      random_run(400, 4'b1010);
      random_run(600, 4'b1111);
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sound_mailbox_fifo.md
# sound_mailbox_fifo

Parametrised, bidirectional command/reply mailbox between the 68k main CPU and the 6502 sound CPU. It generalises the single-byte SNDBUF/68kBUF latch pair to two independent DEPTH-entry FIFOs, with several added behaviours:
- strobe synchronisation;
- first-word-fall-through (FWFT) read data;
- occupancy counts;
- sticky overflow flags;
- a stretchable NMI pulse to the 6502.

It sits between the 68k data bus, the 6502 data bus and the sound-CPU interrupt inputs, all in the clk100 domain.

## Interface
Parameters:
- WIDTH, 8, data width of both FIFOs.
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- NMI_LEN, 32, SNDNMI_b low width in clk100 cycles; ≥1.
- CW = $clog2(DEPTH+1), derived width of the count outputs.

Ports (clock and reset first):
- clk100  in  1  system clock; all state changes on its rising edge.
- rst_b  in  1  reset; asynchronous, active-low.
- Dout68k  in  WIDTH  68k write data.
- SNDWR_b  in  1  68k write strobe (active low); one push per high→low transition.
- SNDRD_b  in  1  68k read strobe (active low); one pop per low→high transition.
- Din68k  out  WIDTH  head of the reply FIFO; all ones when empty.
- SNDINT_b  out  1  low while the reply FIFO is non-empty.
- Dout6502  in  WIDTH  6502 write data.
- WR68k_b  in  1  6502 write strobe (active low); one push per high→low transition.
- RD68k_b  in  1  6502 read strobe (active low); one pop per low→high transition.
- Din6502  out  WIDTH  head of the command FIFO; all ones when empty.
- SNDNMI_b  out  1  NMI to the 6502; low NMI_LEN cycles after each accepted command push.
- ctrl_SNDBUF  out  1  command FIFO non-empty.
- ctrl_68kBUF  out  1  reply FIFO non-empty.
- cmd_count, rpl_count  out  CW  occupancy, 0..DEPTH.
- cmd_full, rpl_full  out  1  count == DEPTH.
- cmd_ovf, rpl_ovf  out  1  sticky; set by a push attempted while full.
- ovf_clr  in  1  synchronous, active high; clears both overflow flags.

## Operation
FIFO topology:
- Command FIFO: the 68k pushes (SNDWR_b) and the 6502 pops (RD68k_b).
- Reply FIFO: the 6502 pushes (WR68k_b) and the 68k pops (SNDRD_b).

Strobe handling:
- Each strobe passes through a 2-flop synchroniser, then a history flop, for edge detection.
- The synchroniser and history flops reset to 0. A strobe held low across reset release therefore causes no operation until it has been seen high and then low again.

Push:
- The push edge is detected when the synchronised strobe is 0 and the history flop is 1.
- Write data is sampled in that same cycle; the bus holds data for the whole strobe-low period.
- Push when full: data is dropped, pointers are unchanged, and the ovf flag is set.

Pop:
- The pop edge is the synchronised rising edge.
- Pop when empty: ignored; no flag is set.

Storage and pointers:
- Storage is a RAM array with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- The count is held separately.
- Read data is FWFT. Din* shows mem[rd_ptr] whenever count > 0, otherwise {WIDTH{1'b1}}.

Simultaneous push and pop on the same FIFO:
- Count > 0, including full: both are performed and the count is unchanged. When full, the push is not counted as an overflow.
- Count == 0: the push is performed and the pop is ignored; count becomes 1.

Overflow flags:
- When ovf_clr coincides with an overflow event, set wins.

NMI:
- NMI is a down-counter loaded with NMI_LEN on each accepted command push; SNDNMI_b = (counter == 0).
- A push during an active pulse reloads the counter and extends the pulse.
- A dropped (overflow) push does not load the counter.

SNDINT_b level and the ctrl_* flags are derived combinationally from the counts.

## Timing
Reset values:
- All counts and pointers = 0.
- ctrl_SNDBUF = ctrl_68kBUF = 0.
- full = ovf = 0.
- SNDNMI_b = SNDINT_b = 1.
- Din68k = Din6502 = all ones.
- NMI counter = 0.

Reset asserted mid-operation discards all FIFO contents and any NMI pulse immediately (asynchronously).

Latency:
- Let E0 be the first rising edge at which a strobe is sampled at its new level.
- The operation commits at E0+2; count, flags, Din* and SNDINT_b reflect it after E0+2.
- SNDNMI_b goes low after E0+2 and returns high exactly NMI_LEN edges later.

Strobe and data requirements:
- Minimum strobe low width and high width: 3 clk100 cycles.
- Write data must be stable from E0 through E0+2.
- A read's data is valid from strobe fall until the pop commits.

Channel independence: the two FIFOs are independent. Concurrent activity on all four strobes in the same cycle is legal.

## Test plan
- Reset: check every output's reset value. Hold SNDWR_b low across release → no push; cmd_count stays 0.
- 68k writes 0x42: cmd_count = 1, ctrl_SNDBUF = 1, Din6502 = 0x42 at E0+2; SNDNMI_b low for exactly 32 cycles. A second write 10 cycles later extends the low time to 42 cycles total.
- DEPTH=4: 68k writes 0x01..0x05 → cmd_full = 1 after the 4th write; 5th write sets cmd_ovf and does not restart NMI. 6502 reads four times → 0x01, 0x02, 0x03, 0x04 in order, then Din6502 = 0xFF; a further read leaves cmd_count = 0.
- Wrap: 10 interleaved write/read pairs on the reply FIFO with data 0xA0+i → every read returns the matching value; SNDINT_b low only while rpl_count > 0.
- Full FIFO, push and pop committing in the same cycle → count stays 4, ovf stays 0, FIFO order is preserved. ovf_clr coinciding with an overflow push → ovf = 1.
- Assert rst_b mid-NMI with 3 entries queued → counts 0, SNDNMI_b = 1 immediately, Din6502 = 0xFF.
